// File: rtl/imac_pkg.sv
// Shared constants for the MAC column: sequencer state encoding, default widths
// and the frame length limit that keeps a frame sum from wrapping.
package imac_pkg;

    localparam int DATA_W_DEF    = 5;
    localparam int SUM_W_DEF     = 14;
    localparam int FRAME_LEN_DEF = 16;
    localparam int CNT_W_DEF     = 10;
    localparam int FRAME_LEN_MAX = 528;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CLEAR   = 3'd1;
    localparam logic [2:0] ST_ACCUM   = 3'd2;
    localparam logic [2:0] ST_SETTLE1 = 3'd3;
    localparam logic [2:0] ST_SETTLE2 = 3'd4;
    localparam logic [2:0] ST_OUTPUT  = 3'd5;

    // True when a full frame of maximum codes still fits in the sum width.
    function automatic bit frame_len_ok(input int n, input int data_w, input int sum_w);
        return (n >= 1) && (n <= FRAME_LEN_MAX) &&
               (((2 ** data_w) - 1) * n < (2 ** sum_w));
    endfunction

endpackage

// File: rtl/acc_frame_sequencer_if.sv
// Stream, accumulator and result signals between the frame sequencer and its
// surroundings (ADC source, accumulator, downstream consumer).
interface acc_frame_sequencer_if
    import imac_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int SUM_W  = SUM_W_DEF
) ();

    logic              start;
    logic              busy;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              acc_clr;
    logic              acc_en;
    logic [DATA_W-1:0] acc_in;
    logic [SUM_W-1:0]  acc_sum;
    logic [SUM_W-1:0]  out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        input  start, in_data, in_valid, acc_sum, out_ready,
        output busy, in_ready, acc_clr, acc_en, acc_in, out_data, out_valid
    );

    modport slave (
        output start, in_data, in_valid, acc_sum, out_ready,
        input  busy, in_ready, acc_clr, acc_en, acc_in, out_data, out_valid
    );

endinterface

// File: rtl/acc_frame_sequencer.sv
// Feeds FRAME_LEN ADC codes into the external accumulator, waits for the sum to
// settle, then hands the frame sum downstream on a valid/ready port.
//
//  state   | meaning
//  IDLE    | waiting for start
//  CLEAR   | acc_clr high, frame counter reset
//  ACCUM   | accepting codes, one acc_en pulse per handshake
//  SETTLE1 | last acc_en high, accumulator updating
//  SETTLE2 | acc_sum final, captured on exit
//  OUTPUT  | out_valid high until out_ready
module acc_frame_sequencer
    import imac_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int SUM_W     = SUM_W_DEF,
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input logic                  clk,
    input logic                  reset_n,
    acc_frame_sequencer_if.master bus
);

    if (!frame_len_ok(FRAME_LEN, DATA_W, SUM_W)) begin : g_bad_frame_len
        $error("acc_frame_sequencer: FRAME_LEN %0d out of range 1..%0d or sum can wrap",
               FRAME_LEN, FRAME_LEN_MAX);
    end
    if ((2 ** CNT_W) < FRAME_LEN) begin : g_bad_cnt_w
        $error("acc_frame_sequencer: CNT_W %0d too narrow for FRAME_LEN %0d", CNT_W, FRAME_LEN);
    end

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

    logic [2:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic              acc_clr_q;
    logic              acc_en_q;
    logic [DATA_W-1:0] acc_in_q;
    logic [SUM_W-1:0]  out_data_q;
    logic              out_valid_q;
    logic              in_hs;

    assign bus.busy      = (state != ST_IDLE);
    assign bus.in_ready  = (state == ST_ACCUM);
    assign bus.acc_clr   = acc_clr_q;
    assign bus.acc_en    = acc_en_q;
    assign bus.acc_in    = acc_in_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;

    assign in_hs = bus.in_valid && (state == ST_ACCUM);

    // acc_clr is raised on the edge entering CLEAR so it lines up with that state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            acc_clr_q   <= 1'b0;
            acc_en_q    <= 1'b0;
            acc_in_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            acc_clr_q <= 1'b0;
            acc_en_q  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        acc_clr_q <= 1'b1;
                        state     <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    cnt   <= '0;
                    state <= ST_ACCUM;
                end
                ST_ACCUM: begin
                    if (in_hs) begin
                        acc_en_q <= 1'b1;
                        acc_in_q <= bus.in_data;
                        cnt      <= cnt + CNT_W'(1);
                        if (cnt == CNT_LAST) begin
                            state <= ST_SETTLE1;
                        end
                    end
                end
                ST_SETTLE1: begin
                    state <= ST_SETTLE2;
                end
                ST_SETTLE2: begin
                    out_data_q  <= bus.acc_sum;
                    out_valid_q <= 1'b1;
                    state       <= ST_OUTPUT;
                end
                ST_OUTPUT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        if (bus.start) begin
                            acc_clr_q <= 1'b1;
                            state     <= ST_CLEAR;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_acc_frame_sequencer.sv
// Directed bench for acc_frame_sequencer with FRAME_LEN=4 and a behavioural
// accumulator standing in for the one in the MAC column wrapper.
module tb_acc_frame_sequencer;
    import imac_pkg::*;

    localparam int DW = 5;
    localparam int SW = 14;
    localparam int FL = 4;
    localparam int CW = 10;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [SW-1:0] acc_model;
    int en_cnt = 0;
    int clr_cnt = 0;
    int overlap = 0;
    int total = 0;
    int bad = 0;

    acc_frame_sequencer_if #(.DATA_W(DW), .SUM_W(SW)) bus ();

    acc_frame_sequencer #(.DATA_W(DW), .SUM_W(SW), .FRAME_LEN(FL), .CNT_W(CW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    assign bus.acc_sum = acc_model;

    always @(posedge clk) begin
        if (bus.acc_clr) acc_model <= '0;
        else if (bus.acc_en) acc_model <= acc_model + SW'(bus.acc_in);
        if (bus.acc_en) en_cnt <= en_cnt + 1;
        if (bus.acc_clr) clr_cnt <= clr_cnt + 1;
        if (bus.acc_en && bus.acc_clr) overlap <= overlap + 1;
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic send_code(input logic [DW-1:0] c);
        int n;
        n = 0;
        bus.in_data  = c;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL send_code: in_ready=%b required 1 (timeout)", bus.in_ready);
        end
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_result(input string name, input logic [SW-1:0] exp);
        int n;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        total++;
        if (n !== 2) begin
            bad++;
            $display("FAIL %s latency: out_valid after %0d cycles, required 2", name, n);
        end
        total++;
        if (bus.out_data !== exp) begin
            bad++;
            $display("FAIL %s out_data: got %0d required %0d", name, bus.out_data, exp);
        end
    endtask

    task automatic accept(input string name);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        total++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL %s accept: out_valid=%b busy=%b required 0 0", name, bus.out_valid, bus.busy);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.start     = 1'($urandom);
            bus.in_valid  = 1'($urandom);
            bus.in_data   = DW'($urandom);
            bus.out_ready = 1'($urandom);
            step();
            total++;
            if ({bus.busy, bus.in_ready, bus.acc_clr, bus.acc_en, bus.acc_in,
                 bus.out_data, bus.out_valid} !== '0) begin
                bad++;
                $display("FAIL reset outputs: busy=%b in_ready=%b acc_clr=%b acc_en=%b acc_in=%0d out_data=%0d out_valid=%b required all 0",
                         bus.busy, bus.in_ready, bus.acc_clr, bus.acc_en, bus.acc_in,
                         bus.out_data, bus.out_valid);
            end
        end
        bus.start = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        int e0, c0;
        e0 = en_cnt;
        c0 = clr_cnt;
        pulse_start();
        total++;
        if (bus.acc_clr !== 1'b1) begin
            bad++;
            $display("FAIL basic acc_clr in CLEAR: got %b required 1", bus.acc_clr);
        end
        for (int i = 1; i <= 4; i++) send_code(DW'(i));
        wait_result("basic", SW'(10));
        total++;
        if (en_cnt - e0 != 4 || clr_cnt - c0 != 1) begin
            bad++;
            $display("FAIL basic pulses: acc_en=%0d acc_clr=%0d required 4 1", en_cnt - e0, clr_cnt - c0);
        end
        accept("basic");
    endtask

    task automatic test_gaps();
        int e0;
        e0 = en_cnt;
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            send_code(DW'(31));
            if (i < 3) begin
                step();
                step();
            end
        end
        wait_result("gaps", SW'(124));
        total++;
        if (en_cnt - e0 != 4) begin
            bad++;
            $display("FAIL gaps acc_en pulses: got %0d required 4", en_cnt - e0);
        end
        accept("gaps");
    endtask

    task automatic test_output_hold();
        pulse_start();
        send_code(DW'(3));
        send_code(DW'(9));
        send_code(DW'(6));
        send_code(DW'(1));
        wait_result("hold", SW'(19));
        for (int i = 0; i < 5; i++) begin
            bus.start = (i == 2);
            step();
            total++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== SW'(19) || bus.acc_clr !== 1'b0) begin
                bad++;
                $display("FAIL hold stable: out_valid=%b out_data=%0d acc_clr=%b required 1 19 0",
                         bus.out_valid, bus.out_data, bus.acc_clr);
            end
        end
        bus.start = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.start = 1'b0;
        bus.out_ready = 1'b0;
        total++;
        if (bus.acc_clr !== 1'b1 || bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL back_to_back: acc_clr=%b out_valid=%b required 1 0", bus.acc_clr, bus.out_valid);
        end
        for (int i = 0; i < 4; i++) send_code(DW'(1));
        wait_result("back_to_back", SW'(4));
        accept("back_to_back");
    endtask

    task automatic test_reset_midframe();
        int e0;
        pulse_start();
        send_code(DW'(7));
        send_code(DW'(7));
        reset_n = 1'b0;
        step();
        total++;
        if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL midframe reset: busy=%b in_ready=%b out_valid=%b required 0 0 0",
                     bus.busy, bus.in_ready, bus.out_valid);
        end
        reset_n = 1'b1;
        step();
        e0 = en_cnt;
        pulse_start();
        for (int i = 0; i < 4; i++) send_code(DW'(5));
        wait_result("after_reset", SW'(20));
        total++;
        if (en_cnt - e0 != 4) begin
            bad++;
            $display("FAIL after_reset acc_en pulses: got %0d required 4", en_cnt - e0);
        end
        accept("after_reset");
    endtask

    task automatic test_ignored();
        int e0, c0;
        e0 = en_cnt;
        bus.in_data = DW'(9);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (bus.in_ready !== 1'b0 || bus.busy !== 1'b0) begin
                bad++;
                $display("FAIL idle in_valid: in_ready=%b busy=%b required 0 0", bus.in_ready, bus.busy);
            end
        end
        bus.in_valid = 1'b0;
        step();
        total++;
        if (en_cnt - e0 != 0) begin
            bad++;
            $display("FAIL idle acc_en pulses: got %0d required 0", en_cnt - e0);
        end
        c0 = clr_cnt;
        pulse_start();
        send_code(DW'(2));
        send_code(DW'(3));
        pulse_start();
        total++;
        if (bus.in_ready !== 1'b1 || bus.acc_clr !== 1'b0) begin
            bad++;
            $display("FAIL start in ACCUM: in_ready=%b acc_clr=%b required 1 0", bus.in_ready, bus.acc_clr);
        end
        send_code(DW'(4));
        send_code(DW'(5));
        wait_result("ignored", SW'(14));
        total++;
        if (en_cnt - e0 != 4 || clr_cnt - c0 != 1) begin
            bad++;
            $display("FAIL ignored pulses: acc_en=%0d acc_clr=%0d required 4 1", en_cnt - e0, clr_cnt - c0);
        end
        accept("ignored");
    endtask

    initial begin
        bus.start = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        step();
        test_reset();
        test_basic();
        test_gaps();
        test_output_hold();
        test_reset_midframe();
        test_ignored();
        total++;
        if (overlap != 0) begin
            bad++;
            $display("FAIL en_clr_overlap: got %0d cycles required 0", overlap);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
